// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: write ports, read ports,
// scoreboard claim and the ready status.
interface regfile_sb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
);
  logic                         ready;
  logic                         we0;
  logic [ADDR_W-1:0]            waddr0;
  logic [DATA_W-1:0]            wdata0;
  logic                         we1;
  logic [ADDR_W-1:0]            waddr1;
  logic [DATA_W-1:0]            wdata1;
  logic [RD_PORTS-1:0]          re;
  logic [RD_PORTS*ADDR_W-1:0]   raddr;
  logic [RD_PORTS*DATA_W-1:0]   rdata;
  logic [RD_PORTS-1:0]          rbusy;
  logic                         sb_set;
  logic [ADDR_W-1:0]            sb_addr;

  // Pipeline side: issues writes, reads and scoreboard claims.
  modport master (
    input  ready, rdata, rbusy,
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output re, raddr, sb_set, sb_addr
  );

  // Register file side.
  modport slave (
    output ready, rdata, rbusy,
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  re, raddr, sb_set, sb_addr
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with per-register pending-write
// scoreboard and a post-reset zeroing sweep. Register 0 reads as zero and
// is never busy. Port 1 is the younger writeback and wins on conflicts.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                ready_q;
  logic [DATA_W-1:0]   regs [NREG];
  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     set_mask;
  logic [NREG-1:0]     clr_mask;
  logic                wr0;
  logic                wr1;

  assign bus.ready = ready_q;

  // Effective writes: only in RUN and never to register 0.
  assign wr0 = ready_q && bus.we0 && (bus.waddr0 != '0);
  assign wr1 = ready_q && bus.we1 && (bus.waddr1 != '0);

  // Init/run sequencer: sweep cnt over 1..NREG-1, then enter RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= ADDR_W'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase
    end
  end

  // Register array: zero fill during the sweep, writeback in RUN (port 1 last so it wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        regs[cnt] <= '0;
      end else begin
        if (wr0) regs[bus.waddr0] <= bus.wdata0;
        if (wr1) regs[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  // Scoreboard set/clear masks; set is ORed in after clear so it wins a collision.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (ready_q) begin
      if (bus.sb_set) set_mask[bus.sb_addr] = 1'b1;
      if (wr0)        clr_mask[bus.waddr0]  = 1'b1;
      if (wr1)        clr_mask[bus.waddr1]  = 1'b1;
    end
    set_mask[0] = 1'b0;
  end

  // Busy bits: cleared by reset, updated from the masks each cycle.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  // Read ports: gating, then port-1 bypass, port-0 bypass, array.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              live;
    logic              hit0;
    logic              hit1;

    assign a    = bus.raddr[p*ADDR_W +: ADDR_W];
    assign live = ready_q && bus.re[p] && (a != '0);
    assign hit1 = bus.we1 && (bus.waddr1 == a);
    assign hit0 = bus.we0 && (bus.waddr0 == a);

    assign bus.rdata[p*DATA_W +: DATA_W] = !live ? '0          :
                                           hit1  ? bus.wdata1  :
                                           hit0  ? bus.wdata0  :
                                                   regs[a];
    // A same-cycle writeback hides the pending bit it is about to clear.
    assign bus.rbusy[p] = live && !hit0 && !hit1 && busy[a];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected outputs from an
// array-based model; a negedge monitor pops and compares.
module tb_regfile_sb;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int RP   = 3;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) bus ();
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string            name;
    logic             rdy;
    logic [RP*DW-1:0] rd;
    logic [RP-1:0]    rb;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model
  logic [DW-1:0] mem [NREG];
  bit            bsy [NREG];
  int            init_cnt = 0;

  function automatic bit m_ready();
    return init_cnt >= NREG - 1;
  endfunction

  function automatic logic [RP*AW-1:0] pk(input int a0, input int a1, input int a2);
    logic [AW-1:0] x0, x1, x2;
    x0 = AW'(a0); x1 = AW'(a1); x2 = AW'(a2);
    return {x2, x1, x0};
  endfunction

  task automatic step(input string name, input logic r,
                      input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [RP-1:0] re_i, input logic [RP*AW-1:0] ra,
                      input logic s, input logic [AW-1:0] sa);
    exp_t          e;
    logic [AW-1:0] a;
    bit            rdy;
    rst        = r;
    bus.we0    = w0; bus.waddr0 = a0; bus.wdata0 = d0;
    bus.we1    = w1; bus.waddr1 = a1; bus.wdata1 = d1;
    bus.re     = re_i; bus.raddr = ra;
    bus.sb_set = s; bus.sb_addr = sa;
    rdy    = m_ready();
    e.name = name;
    e.rdy  = rdy;
    e.rd   = '0;
    e.rb   = '0;
    for (int p = 0; p < RP; p++) begin
      a = ra[p*AW +: AW];
      if (rdy && re_i[p] && a != 0) begin
        if (w1 && a1 == a)      e.rd[p*DW +: DW] = d1;
        else if (w0 && a0 == a) e.rd[p*DW +: DW] = d0;
        else                    e.rd[p*DW +: DW] = mem[a];
        e.rb[p] = ((w0 && a0 == a) || (w1 && a1 == a)) ? 1'b0 : bsy[a];
      end
    end
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      init_cnt = 0;
      for (int i = 0; i < NREG; i++) begin
        bsy[i] = 1'b0;
        mem[i] = '0;
      end
    end else if (!rdy) begin
      init_cnt++;
    end else begin
      if (w0 && a0 != 0) mem[a0] = d0;
      if (w1 && a1 != 0) mem[a1] = d1;
      if (w0 && a0 != 0) bsy[a0] = 1'b0;
      if (w1 && a1 != 0) bsy[a1] = 1'b0;
      if (s && sa != 0)  bsy[sa] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input string name, input logic r,
                      input logic [RP-1:0] re_i, input logic [RP*AW-1:0] ra);
    step(name, r, 1'b0, '0, '0, 1'b0, '0, '0, re_i, ra, 1'b0, '0);
  endtask

  task automatic rnd_step(input string name, input logic r, input int amax);
    step(name, r,
         1'($urandom), AW'($urandom_range(0, amax)), DW'($urandom),
         1'($urandom), AW'($urandom_range(0, amax)), DW'($urandom),
         RP'($urandom),
         pk($urandom_range(0, amax), $urandom_range(0, amax), $urandom_range(0, amax)),
         1'($urandom), AW'($urandom_range(0, amax)));
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_cmp++;
      if (bus.ready !== mon_e.rdy) begin
        n_bad++;
        $display("FAIL %s ready: got %0b want %0b", mon_e.name, bus.ready, mon_e.rdy);
      end
      n_cmp++;
      if (bus.rdata !== mon_e.rd) begin
        n_bad++;
        $display("FAIL %s rdata: got %h want %h", mon_e.name, bus.rdata, mon_e.rd);
      end
      n_cmp++;
      if (bus.rbusy !== mon_e.rb) begin
        n_bad++;
        $display("FAIL %s rbusy: got %b want %b", mon_e.name, bus.rbusy, mon_e.rb);
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1;
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.re = '0; bus.raddr = '0; bus.sb_set = 1'b0; bus.sb_addr = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREG; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end

    // Reset held, then full sweep with ignored write/claim attempts
    idle("rst", 1'b1, '1, pk(1, 2, 3));
    idle("rst", 1'b1, '1, pk(4, 5, 6));
    for (int i = 0; i < NREG - 1; i++) rnd_step("init", 1'b0, NREG - 1);
    for (int i = 0; i < 11; i++)
      idle("zero_rd", 1'b0, '1, pk((1 + 3*i) % NREG, (2 + 3*i) % NREG, (3 + 3*i) % NREG));

    // Reset at sweep cycle 10 restarts the full sweep
    idle("rst2", 1'b1, '1, pk(1, 2, 3));
    for (int i = 0; i < 10; i++) rnd_step("sweep_a", 1'b0, NREG - 1);
    idle("rst_mid", 1'b1, '1, pk(1, 2, 3));
    for (int i = 0; i < NREG - 1; i++) rnd_step("sweep_b", 1'b0, NREG - 1);
    idle("post_sweep", 1'b0, '1, pk(5, 9, 31));

    // Dual-write priority on r5
    step("dual", 1'b0, 1'b1, 5, 32'h11111111, 1'b1, 5, 32'h22222222,
         3'b111, pk(5, 5, 0), 1'b0, 0);
    idle("dual_next", 1'b0, 3'b001, pk(5, 0, 0));

    // Register zero
    step("r0_wr", 1'b0, 1'b0, 0, 0, 1'b1, 0, 32'hFFFFFFFF, 3'b111, pk(0, 0, 0), 1'b1, 0);
    idle("r0_rd", 1'b0, 3'b111, pk(0, 0, 0));

    // Scoreboard lifecycle on r7
    step("sb7_set", 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 3'b001, pk(7, 0, 0), 1'b1, 7);
    idle("sb7_busy", 1'b0, 3'b011, pk(7, 7, 0));
    d = DW'($urandom);
    step("sb7_wb", 1'b0, 1'b1, 7, d, 1'b0, 0, 0, 3'b001, pk(7, 0, 0), 1'b0, 0);
    idle("sb7_after", 1'b0, 3'b001, pk(7, 0, 0));

    // Set/clear collision on r9
    step("sb9_set", 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 3'b000, pk(0, 0, 0), 1'b1, 9);
    idle("sb9_busy", 1'b0, 3'b100, pk(0, 0, 9));
    step("col", 1'b0, 1'b0, 0, 0, 1'b1, 9, 32'hA5A5A5A5, 3'b001, pk(9, 0, 0), 1'b1, 9);
    idle("col_next", 1'b0, 3'b001, pk(9, 0, 0));

    // Read enables across three ports
    step("re_wr", 1'b0, 1'b1, 3, 32'h33330003, 1'b1, 4, 32'h44440004, 3'b000, pk(0, 0, 0), 1'b0, 0);
    step("re_wr", 1'b0, 1'b1, 6, 32'h66660006, 1'b0, 0, 0, 3'b000, pk(0, 0, 0), 1'b0, 0);
    idle("re101", 1'b0, 3'b101, pk(3, 4, 6));
    idle("re010", 1'b0, 3'b010, pk(3, 4, 6));

    // Random traffic over a narrow address range to force collisions
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) rnd_step("rnd_rst", 1'b1, 7);
      else                             rnd_step("rnd", 1'b0, 7);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
